// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: big-endian word-count header, then 32-bit words.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic [31:0] mem_write_address_o,
  output logic [31:0] mem_write_data_o,
  output logic        mem_write_o,
  output logic        cpu_reset_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [2:0]  state_o
);

  // Byte handshake: a byte moves on a rising edge where byte_valid_i and
  // byte_ready_o are both high; byte_ready_o depends on the state only.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_HI = 3'd1,
    S_HDR_LO = 3'd2,
    S_LOAD   = 3'd3,
    S_WRITE  = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHECK  = 3'd5,
`endif
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_e;

  // Clamp so word counts above the 16-bit header range never flag an overflow.
  localparam logic [16:0] MAX_WORDS = (ADDR_WIDTH >= 16) ? 17'h10000 : 17'(1 << ADDR_WIDTH);

  state_e      state_q, state_d;
  logic [15:0] n_q, n_d;
  logic [15:0] index_q, index_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] word_q, word_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif
  logic        fire;
  state_e      finish_state;

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign finish_state = S_CHECK;
`else
  assign finish_state = S_DONE;
`endif

  assign fire = byte_valid_i & byte_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      index_q    <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      index_q    <= index_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    index_d    = index_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    addr_d     = addr_q;
    data_d     = data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
    if (fire && state_q != S_CHECK) csum_d = csum_q ^ byte_i;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          state_d    = S_HDR_HI;
          n_d        = '0;
          index_d    = '0;
          byte_cnt_d = '0;
          word_d     = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      S_HDR_HI: begin
        if (fire) begin
          n_d     = {byte_i, 8'h00};
          state_d = S_HDR_LO;
        end
      end
      S_HDR_LO: begin
        if (fire) begin
          n_d = {n_q[15:8], byte_i};
          if (n_d == 16'd0)                 state_d = finish_state;
          else if ({1'b0, n_d} > MAX_WORDS) state_d = S_ERROR;
          else                              state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (fire) begin
          word_d     = {word_q[23:0], byte_i};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Latch address/data on entry so they hold until the next write.
            addr_d  = BASE_ADDR + {14'b0, index_q, 2'b00};
            data_d  = word_d;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        index_d = index_q + 16'd1;
        state_d = (index_d == n_q) ? finish_state : S_LOAD;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (fire) state_d = (byte_i == csum_q) ? S_DONE : S_ERROR;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    byte_ready_o = 1'b0;
    busy_o       = 1'b0;
    case (state_q)
      S_HDR_HI, S_HDR_LO, S_LOAD: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
      end
      S_WRITE: busy_o = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: begin
        byte_ready_o = 1'b1;
        busy_o       = 1'b1;
      end
`endif
      default: begin
        byte_ready_o = 1'b0;
        busy_o       = 1'b0;
      end
    endcase
  end

  assign mem_write_o         = (state_q == S_WRITE);
  assign mem_write_address_o = addr_q;
  assign mem_write_data_o    = data_q;
  assign done_o              = (state_q == S_DONE);
  assign error_o             = (state_q == S_ERROR);
  assign cpu_reset_o         = (state_q != S_DONE);
  assign state_o             = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed loads, gaps, overflow, reset abort, start handling.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        mem_write;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  state;

  logic [63:0] exp_q[$];
  logic [31:0] words[0:MAXW-1];
  int          asserts = 0;
  int          fails = 0;

  imem_loader #(.ADDR_WIDTH(8), .BASE_ADDR(BASE)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .byte_i(byte_in),
    .byte_valid_i(byte_valid), .byte_ready_o(byte_ready),
    .mem_write_address_o(wr_addr), .mem_write_data_o(wr_data),
    .mem_write_o(mem_write), .cpu_reset_o(cpu_reset), .busy_o(busy),
    .done_o(done), .error_o(error), .state_o(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n && mem_write) begin
      if (exp_q.size() == 0) begin
        asserts++;
        fails++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", wr_addr, wr_data);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("write_addr", {32'h0, wr_addr}, {32'h0, e[63:32]});
        chk("write_data", {32'h0, wr_data}, {32'h0, e[31:0]});
        chk("ready_in_write", {63'h0, byte_ready}, 64'h0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 1'b0;
    byte_valid = 1'b0;
    repeat (gap) @(posedge clk);
    #1;
    byte_valid = 1'b1;
    byte_in    = b;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (byte_ready) begin
        @(posedge clk);
        ok = 1'b1;
        break;
      end
    end
    #1;
    byte_valid = 1'b0;
    if (!ok) chk("byte_accept_timeout", 64'h0, 64'h1);
  endtask

  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Sends header, data words (if n fits) and, when compiled in, the checksum byte.
  task automatic send_load(input logic [15:0] n, input int gap, input bit bad_csum);
    logic [7:0] csum = 8'h00;
    logic [31:0] w;
    send_byte(n[15:8], gap); csum ^= n[15:8];
    send_byte(n[7:0], gap);  csum ^= n[7:0];
    if (n <= MAXW) begin
      for (int i = 0; i < int'(n); i++) begin
        w = words[i];
        for (int k = 0; k < 4; k++) begin
          if (k == 3) exp_q.push_back({BASE + 32'(4 * i), w});
          send_byte(w[31-8*k -: 8], gap);
          csum ^= w[31-8*k -: 8];
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(bad_csum ? 8'h00 : csum, gap);
`else
      if (bad_csum) csum = 8'h00;
`endif
    end
  endtask

  task automatic wait_end(input string name, input bit exp_done, input bit exp_err);
    bit seen = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (done || error) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) $display("FAIL %s_timeout: got no done/error expected completion", name);
    chk({name, "_seen"}, {63'h0, seen}, 64'h1);
    chk({name, "_done"}, {63'h0, done}, {63'h0, exp_done});
    chk({name, "_error"}, {63'h0, error}, {63'h0, exp_err});
    chk({name, "_cpu_reset"}, {63'h0, cpu_reset}, {63'h0, !exp_done});
    chk({name, "_busy"}, {63'h0, busy}, 64'h0);
    chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'h0);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_ready"}, {63'h0, byte_ready}, 64'h0);
    chk({name, "_memwrite"}, {63'h0, mem_write}, 64'h0);
    chk({name, "_addr"}, {32'h0, wr_addr}, 64'h0);
    chk({name, "_data"}, {32'h0, wr_data}, 64'h0);
    chk({name, "_cpu_reset"}, {63'h0, cpu_reset}, 64'h1);
    chk({name, "_busy"}, {63'h0, busy}, 64'h0);
    chk({name, "_done"}, {63'h0, done}, 64'h0);
    chk({name, "_error"}, {63'h0, error}, 64'h0);
  endtask

  initial begin
    #3 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single word, no gaps.
    words[0] = 32'h8C01_0004;
    do_start();
    send_load(16'd1, 0, 1'b0);
    wait_end("single", 1'b1, 1'b0);

    // Start in DONE restarts; two words with 3-cycle gaps.
    words[0] = 32'h1122_3344;
    words[1] = 32'hDEAD_BEEF;
    do_start();
    chk("restart_done", {63'h0, done}, 64'h0);
    chk("restart_cpu_reset", {63'h0, cpu_reset}, 64'h1);
    chk("restart_busy", {63'h0, busy}, 64'h1);
    send_load(16'd2, 3, 1'b0);
    wait_end("gaps", 1'b1, 1'b0);
    chk("hold_addr", {32'h0, wr_addr}, {32'h0, BASE + 32'h4});
    chk("hold_data", {32'h0, wr_data}, 64'hDEAD_BEEF);

    // Overflow: 257 words into a 256-word memory.
    do_start();
    send_load(16'd257, 0, 1'b0);
    wait_end("overflow", 1'b0, 1'b1);

    // Zero-length load, started from ERROR.
    do_start();
    send_load(16'd0, 0, 1'b0);
    wait_end("zero", 1'b1, 1'b0);

    // Largest legal load fills the whole memory.
    for (int i = 0; i < MAXW; i++) words[i] = {8'(i), ~8'(i), 8'h5A, 8'(i) ^ 8'h3C};
    do_start();
    send_load(16'd256, 0, 1'b0);
    wait_end("full", 1'b1, 1'b0);

    // Reset after two of four data bytes, then a clean reload.
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    @(posedge clk);
    #1 rst_n = 1'b1;
    words[0] = 32'hCAFE_F00D;
    words[1] = 32'h0123_4567;
    do_start();
    send_load(16'd2, 1, 1'b0);
    wait_end("reload", 1'b1, 1'b0);

    // Start pulsed mid-word is ignored.
    do_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h76, 0);
    send_byte(8'h54, 0);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("start_ignored_busy", {63'h0, busy}, 64'h1);
    exp_q.push_back({BASE, 32'h7654_3210});
    send_byte(8'h32, 0);
    send_byte(8'h10, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'h00 ^ 8'h01 ^ 8'h76 ^ 8'h54 ^ 8'h32 ^ 8'h10, 0);
`endif
    wait_end("start_in_load", 1'b1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum 0x09 is the XOR of 00 01 12 34 56 78.
    words[0] = 32'h1234_5678;
    do_start();
    send_load(16'd1, 0, 1'b0);
    wait_end("csum_ok", 1'b1, 1'b0);
    do_start();
    send_load(16'd1, 0, 1'b1);
    wait_end("csum_bad", 1'b0, 1'b1);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
